// File: rtl/knn_topk_sel_pkg.sv
// Shared definitions for the KNN top-K selector: state encodings, list bounds and rank-width helper.
package knn_topk_sel_pkg;

    localparam int KNN_K_MAX = 16;
    localparam int CNT_W     = $clog2(KNN_K_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_VOTE    = 3'd2,
        ST_READOUT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic int rank_w(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/knn_topk_slot.sv
// One entry of the sorted top-K list: valid/dist/label registers plus the "new sample beats me" flag.
module knn_topk_slot #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               ins_i,
    input  logic [DATA_W-1:0]  new_dist_i,
    input  logic [LABEL_W-1:0] new_label_i,
    input  logic               prev_lt_i,
    input  logic               prev_valid_i,
    input  logic [DATA_W-1:0]  prev_dist_i,
    input  logic [LABEL_W-1:0] prev_label_i,
    output logic               lt_o,
    output logic               valid_o,
    output logic [DATA_W-1:0]  dist_o,
    output logic [LABEL_W-1:0] label_o
);

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  dist_q, dist_d;
    logic [LABEL_W-1:0] label_q, label_d;

    // Empty slots behave as +inf; strict compare keeps earlier equal distances ahead.
    assign lt_o = !valid_q || (new_dist_i < dist_q);

    always_comb begin
        valid_d = valid_q;
        dist_d  = dist_q;
        label_d = label_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (ins_i) begin
            if (prev_lt_i) begin
                valid_d = prev_valid_i;
                dist_d  = prev_dist_i;
                label_d = prev_label_i;
            end else if (lt_o) begin
                valid_d = 1'b1;
                dist_d  = new_dist_i;
                label_d = new_label_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            dist_q  <= '0;
            label_q <= '0;
        end else begin
            valid_q <= valid_d;
            dist_q  <= dist_d;
            label_q <= label_d;
        end
    end

    assign valid_o = valid_q;
    assign dist_o  = dist_q;
    assign label_o = label_q;

endmodule

// File: rtl/knn_topk_sel.sv
// Top-K nearest-neighbour selector: sorted single-cycle insert, then ranked readout.
// Optional majority vote over the kept labels is enabled by defining KNN_TOPK_VOTE_EN.
module knn_topk_sel
    import knn_topk_sel_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 8,
    parameter int K       = 4,
    localparam int RANK_W = rank_w(K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_dist,
    input  logic [LABEL_W-1:0] in_label,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_dist,
    output logic [LABEL_W-1:0] out_label,
    output logic [RANK_W-1:0]  out_rank,
    output logic               out_last,
    output logic               busy,
    output logic               done
`ifdef KNN_TOPK_VOTE_EN
    ,
    output logic [LABEL_W-1:0] vote_label,
    output logic               vote_valid
`endif
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [RANK_W-1:0]   rank_q, rank_d;
    logic [CNT_W-1:0]    last_idx;
    logic                accept;
    logic                clr;

    logic               slot_lt    [K];
    logic               slot_valid [K];
    logic [DATA_W-1:0]  slot_dist  [K];
    logic [LABEL_W-1:0] slot_label [K];
    logic               prev_lt    [K];
    logic               prev_valid [K];
    logic [DATA_W-1:0]  prev_dist  [K];
    logic [LABEL_W-1:0] prev_label [K];

    assign accept   = in_valid && in_ready;
    assign clr      = (state_q == ST_IDLE) && start;
    assign last_idx = n_q - CNT_W'(1);

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_slot
            if (gi == 0) begin : g_head
                assign prev_lt[gi]    = 1'b0;
                assign prev_valid[gi] = 1'b0;
                assign prev_dist[gi]  = '0;
                assign prev_label[gi] = '0;
            end else begin : g_body
                assign prev_lt[gi]    = slot_lt[gi-1];
                assign prev_valid[gi] = slot_valid[gi-1];
                assign prev_dist[gi]  = slot_dist[gi-1];
                assign prev_label[gi] = slot_label[gi-1];
            end
            knn_topk_slot #(
                .DATA_W  (DATA_W),
                .LABEL_W (LABEL_W)
            ) u_slot (
                .clk          (clk),
                .rst          (rst),
                .clr_i        (clr),
                .ins_i        (accept),
                .new_dist_i   (in_dist),
                .new_label_i  (in_label),
                .prev_lt_i    (prev_lt[gi]),
                .prev_valid_i (prev_valid[gi]),
                .prev_dist_i  (prev_dist[gi]),
                .prev_label_i (prev_label[gi]),
                .lt_o         (slot_lt[gi]),
                .valid_o      (slot_valid[gi]),
                .dist_o       (slot_dist[gi]),
                .label_o      (slot_label[gi])
            );
        end
    endgenerate

    assign in_ready  = (state_q == ST_COLLECT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign out_valid = (state_q == ST_READOUT);
    // The slot array is frozen during readout, so the muxed beat is stable under backpressure.
    assign out_dist  = out_valid ? slot_dist[rank_q]  : '0;
    assign out_label = out_valid ? slot_label[rank_q] : '0;
    assign out_rank  = out_valid ? rank_q : '0;
    assign out_last  = out_valid && (CNT_W'(rank_q) == last_idx);

`ifdef KNN_TOPK_VOTE_EN
    logic [RANK_W-1:0]  vj_q, vj_d;
    logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic [LABEL_W-1:0] vote_label_q, vote_label_d;
    logic               vote_valid_q, vote_valid_d;
    logic [CNT_W-1:0]   occ_cnt;

    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < K; i++) begin
            if (slot_valid[i] && (slot_label[i] == slot_label[vj_q])) begin
                occ_cnt = occ_cnt + CNT_W'(1);
            end
        end
    end

    assign vote_label = vote_label_q;
    assign vote_valid = vote_valid_q;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rank_d  = rank_q;
`ifdef KNN_TOPK_VOTE_EN
        vj_d         = vj_q;
        best_cnt_d   = best_cnt_q;
        vote_label_d = vote_label_q;
        vote_valid_d = vote_valid_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    n_d     = '0;
                    rank_d  = '0;
`ifdef KNN_TOPK_VOTE_EN
                    vj_d         = '0;
                    best_cnt_d   = '0;
                    vote_label_d = '0;
                    vote_valid_d = 1'b0;
`endif
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    if (n_q != CNT_W'(K)) begin
                        n_d = n_q + CNT_W'(1);
                    end
                    if (in_last) begin
`ifdef KNN_TOPK_VOTE_EN
                        state_d = ST_VOTE;
`else
                        state_d = ST_READOUT;
`endif
                    end
                end
            end
`ifdef KNN_TOPK_VOTE_EN
            ST_VOTE: begin
                // Strictly-greater replacement leaves ties with the nearer rank.
                if (occ_cnt > best_cnt_q) begin
                    best_cnt_d   = occ_cnt;
                    vote_label_d = slot_label[vj_q];
                end
                if (CNT_W'(vj_q) == last_idx) begin
                    state_d      = ST_READOUT;
                    vote_valid_d = 1'b1;
                    vj_d         = '0;
                end else begin
                    vj_d = vj_q + RANK_W'(1);
                end
            end
`endif
            ST_READOUT: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = ST_DONE;
                        rank_d  = '0;
                    end else begin
                        rank_d = rank_q + RANK_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            rank_q  <= '0;
`ifdef KNN_TOPK_VOTE_EN
            vj_q         <= '0;
            best_cnt_q   <= '0;
            vote_label_q <= '0;
            vote_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rank_q  <= rank_d;
`ifdef KNN_TOPK_VOTE_EN
            vj_q         <= vj_d;
            best_cnt_q   <= best_cnt_d;
            vote_label_q <= vote_label_d;
            vote_valid_q <= vote_valid_d;
`endif
        end
    end

endmodule
